// File: rtl/result_accumulator.sv
// Block accumulator: sums BLOCK_LEN unsigned samples and hands one summary downstream per block.
// Build with RESULT_ACC_MAX_TRACK_EN defined to also report the block maximum on out_max.
module result_accumulator #(
    parameter int DATA_W    = 16,
    parameter int BLOCK_LEN = 4,
    parameter int SUM_W     = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SUM_W-1:0]  out_sum,
    output logic [DATA_W-1:0] out_max,
    output logic              busy
);

    // Eight bits covers the full legal BLOCK_LEN range of 1..255.
    localparam int               CNT_W = 8;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(BLOCK_LEN);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DONE
    } state_t;

    state_t            state;
    logic [SUM_W-1:0]  acc;
    logic [CNT_W-1:0]  cnt;
    logic [SUM_W-1:0]  acc_next;
    logic [CNT_W-1:0]  cnt_next;
    logic              accept;
    logic              last;

    function automatic logic [SUM_W-1:0] widen(input logic [DATA_W-1:0] d);
        return SUM_W'(d);
    endfunction

    assign accept   = in_valid && in_ready;
    assign acc_next = acc + widen(in_data);
    assign cnt_next = cnt + CNT_W'(1);
    assign last     = (cnt_next == LAST);

`ifdef RESULT_ACC_MAX_TRACK_EN
    logic [DATA_W-1:0] run_max;
    logic [DATA_W-1:0] max_next;
    logic [DATA_W-1:0] max_q;

    // Strict greater-than keeps the stored value on ties.
    function automatic logic [DATA_W-1:0] pick_max(input logic [DATA_W-1:0] cur,
                                                   input logic [DATA_W-1:0] cand);
        return (cand > cur) ? cand : cur;
    endfunction

    assign max_next = pick_max(run_max, in_data);
    assign out_max  = max_q;
`else
    assign out_max  = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            out_sum   <= '0;
`ifdef RESULT_ACC_MAX_TRACK_EN
            run_max   <= '0;
            max_q     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= COLLECT;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        acc      <= '0;
                        cnt      <= '0;
`ifdef RESULT_ACC_MAX_TRACK_EN
                        run_max  <= '0;
`endif
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        acc <= acc_next;
                        cnt <= cnt_next;
`ifdef RESULT_ACC_MAX_TRACK_EN
                        run_max <= max_next;
`endif
                        // Summary registers capture the totals including this final sample.
                        if (last) begin
                            state     <= DONE;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            out_sum   <= acc_next;
`ifdef RESULT_ACC_MAX_TRACK_EN
                            max_q     <= max_next;
`endif
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_accumulator.sv
// Directed plus randomized bench for result_accumulator; expected sums and maxima come from a sample queue.
module tb_result_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, in_valid, out_ready;
    logic [15:0] in_data;
    logic        in_ready, out_valid, busy;
    logic [23:0] out_sum;
    logic [15:0] out_max;

    logic        start_w, in_valid_w, out_ready_w;
    logic [15:0] in_data_w;
    logic        in_ready_w, out_valid_w, busy_w;
    logic [23:0] out_sum_w;
    logic [15:0] out_max_w;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] q[$];

    always #5 clk = ~clk;

    result_accumulator dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_max(out_max), .busy(busy)
    );

    result_accumulator #(.DATA_W(16), .BLOCK_LEN(255), .SUM_W(24)) dut_w (
        .clk(clk), .rst_n(rst_n), .start(start_w), .in_valid(in_valid_w), .in_data(in_data_w),
        .in_ready(in_ready_w), .out_valid(out_valid_w), .out_ready(out_ready_w),
        .out_sum(out_sum_w), .out_max(out_max_w), .busy(busy_w)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] q_sum();
        longint s = 0;
        foreach (q[i]) s += q[i];
        return 32'(s % 64'd16777216);
    endfunction

    function automatic logic [31:0] q_max();
        logic [15:0] m = '0;
`ifdef RESULT_ACC_MAX_TRACK_EN
        foreach (q[i]) if (q[i] > m) m = q[i];
`endif
        return 32'(m);
    endfunction

    task automatic begin_block();
        q.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_in_ready", in_ready, 1);
        chk("start_busy", busy, 1);
    endtask

    task automatic feed(input logic [15:0] d, input int gap);
        for (int g = 0; g < gap; g++) begin
            chk("gap_in_ready", in_ready, 1);
            chk("gap_out_valid", out_valid, 0);
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = d;
        q.push_back(d);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic expect_done(input string tag);
        chk({tag, "_out_valid"}, out_valid, 1);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_sum"}, out_sum, q_sum());
        chk({tag, "_max"}, out_max, q_max());
    endtask

    task automatic drain(input int hold);
        for (int h = 0; h < hold; h++) begin
            expect_done("stall");
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("drain_out_valid", out_valid, 0);
        chk("drain_busy", busy, 0);
        chk("drain_in_ready", in_ready, 0);
        chk("drain_sum_kept", out_sum, q_sum());
        chk("drain_max_kept", out_max, q_max());
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b1; in_valid = 1'b1; in_data = 16'd5; out_ready = 1'b0;
        start_w = 1'b1; in_valid_w = 1'b1; in_data_w = 16'd5; out_ready_w = 1'b0;

        // Reset held with start and in_valid asserted.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_busy", busy, 0);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_sum", out_sum, 0);
            chk("rst_max", out_max, 0);
            chk("rst_w_busy", busy_w, 0);
        end
        rst_n = 1'b1; start = 1'b0; in_valid = 1'b0;
        start_w = 1'b0; in_valid_w = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 0);

        // Nominal block with latency tracking.
        begin_block();
        begin
            logic [15:0] nom[4] = '{16'd4, 16'd9, 16'd16, 16'd25};
            for (int i = 0; i < 4; i++) begin
                chk("nom_early_valid", out_valid, 0);
                feed(nom[i], 0);
            end
        end
        expect_done("nom");
        chk("nom_sum_54", out_sum, 32'd54);
`ifdef RESULT_ACC_MAX_TRACK_EN
        chk("nom_max_25", out_max, 32'd25);
`else
        chk("nom_max_0", out_max, 32'd0);
`endif
        drain(0);

        // Stalls and backpressure.
        begin_block();
        feed(16'h0004, 0);
        feed(16'hFFFF, 3);
        feed(16'h0001, 0);
        feed(16'h0010, 0);
        expect_done("stall_blk");
        chk("stall_sum", out_sum, 32'h010014);
        drain(4);

        // Ignored start / in_valid.
        begin_block();
        start = 1'b1;
        feed(16'd11, 0);
        feed(16'd22, 0);
        feed(16'd33, 0);
        feed(16'd44, 0);
        expect_done("ign");
        in_valid = 1'b1; in_data = 16'd999;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            expect_done("ign_done");
        end
        start = 1'b0; in_valid = 1'b0;
        drain(0);
        in_valid = 1'b1; in_data = 16'd500;
        @(negedge clk);
        in_valid = 1'b0;
        chk("idle_valid_busy", busy, 0);
        chk("idle_valid_sum", out_sum, q_sum());
        q.delete();
        start = 1'b1; in_valid = 1'b1; in_data = 16'd777;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b0;
        chk("startvalid_in_ready", in_ready, 1);
        for (int i = 0; i < 4; i++) feed(16'd1, 0);
        expect_done("startvalid");
        chk("startvalid_sum4", out_sum, 32'd4);
        drain(1);

        // Reset mid-block.
        begin_block();
        feed(16'd7, 0);
        feed(16'd8, 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_busy", busy, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_sum", out_sum, 0);
        chk("midrst_max", out_max, 0);
        begin_block();
        for (int i = 1; i <= 4; i++) feed(16'(i), 0);
        expect_done("after_rst");
        chk("after_rst_sum10", out_sum, 32'd10);
        drain(1);

        // Randomized blocks.
        for (int b = 0; b < 8; b++) begin
            begin_block();
            for (int i = 0; i < 4; i++)
                feed(16'($urandom_range(0, 65535)), int'($urandom_range(0, 2)));
            expect_done("rand");
            drain(int'($urandom_range(0, 3)));
        end

        // Full-width block of 255 maximum samples.
        start_w = 1'b1;
        @(negedge clk);
        start_w = 1'b0;
        chk("wide_in_ready", in_ready_w, 1);
        in_valid_w = 1'b1; in_data_w = 16'hFFFF;
        for (int i = 0; i < 254; i++) @(negedge clk);
        chk("wide_not_yet", out_valid_w, 0);
        @(negedge clk);
        in_valid_w = 1'b0;
        chk("wide_out_valid", out_valid_w, 1);
        chk("wide_sum", out_sum_w, 32'hFEFF01);
`ifdef RESULT_ACC_MAX_TRACK_EN
        chk("wide_max", out_max_w, 32'hFFFF);
`else
        chk("wide_max", out_max_w, 32'h0);
`endif
        out_ready_w = 1'b1;
        @(negedge clk);
        out_ready_w = 1'b0;
        chk("wide_drain", out_valid_w, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
